hconv_row_sequencer: RTL and testbench

//  Sequences a pixel stream into the horizontal Gaussian datapath (hin/hrowend/hclrbuffer/step).

---
 rtl/hconv_row_sequencer_if.sv | 25 ++
 rtl/hconv_row_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_hconv_row_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hconv_row_sequencer_if.sv
// Stream-in, datapath and stream-out signals of the horizontal row sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface hconv_row_sequencer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] hin;
  logic [1:0]  hrowend;
  logic        hclrbuffer;
  logic        step;
  logic [15:0] hout;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;

  modport master (
    input  s_data, s_valid, hout,
    output s_ready, hin, hrowend, hclrbuffer, step, m_data, m_valid, m_last
  );

  modport slave (
    output s_data, s_valid, hout,
    input  s_ready, hin, hrowend, hclrbuffer, step, m_data, m_valid, m_last
  );
endinterface

// File: rtl/hconv_row_sequencer.sv
// Feeds rows of pixels into the horizontal Gaussian datapath with edge tags and
// inter-row flushes, and rebuilds a valid/last output stream from its result.
module hconv_row_sequencer #(
  parameter logic [15:0] IMG_W  = 16'd512,
  parameter logic [15:0] IMG_H  = 16'd512,
  parameter logic [15:0] DP_LAT = 16'd1043,
  parameter logic [7:0]  GAP    = 8'd4
) (
  input  logic                  clk,
  input  logic                  hres_n,
  input  logic                  start,
  input  logic                  abort,
  hconv_row_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underrun,
  output logic [15:0]           row_idx
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ROW, S_FLUSH, S_GAP, S_DONE} state_e;
  typedef enum logic [1:0] {O_IDLE, O_WAIT, O_EMIT} ostate_e;

  state_e      state_q, state_d;
  ostate_e     ost_q, ost_d;
  logic [15:0] col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] row_q, row_d;
  logic        err_q, err_d;
  logic [15:0] hin_q, hin_d;
  logic [1:0]  tag_q, tag_d;
  logic        clr_q, clr_d;
  logic        step_q, step_d;
  logic [15:0] dly_q, dly_d;
  logic [15:0] ocol_q, ocol_d;
  logic [15:0] mdata_q, mdata_d;
  logic        mvalid_q, mvalid_d;
  logic        mlast_q, mlast_d;

  logic last_col;
  logic gap_end;
  logic w_one;

  assign last_col = (col_q == IMG_W - 16'd1);
  assign gap_end  = ({1'b0, cnt_q} + 17'd1) >= {9'd0, GAP};
  assign w_one    = (IMG_W == 16'd1);

  always_comb begin
    state_d  = state_q;
    ost_d    = ost_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    err_d    = err_q;
    dly_d    = dly_q;
    ocol_d   = ocol_q;
    hin_d    = '0;
    tag_d    = 2'b00;
    clr_d    = 1'b0;
    step_d   = 1'b0;
    mdata_d  = '0;
    mvalid_d = 1'b0;
    mlast_d  = 1'b0;

    // Output side: a single delay counter is enough because FLUSH >= DP_LAT
    // keeps consecutive rows from overlapping at the datapath output.
    case (ost_q)
      O_WAIT: begin
        if (dly_q == DP_LAT) begin
          mvalid_d = 1'b1;
          mdata_d  = bus.hout;
          mlast_d  = w_one;
          ocol_d   = 16'd1;
          ost_d    = w_one ? O_IDLE : O_EMIT;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      O_EMIT: begin
        mvalid_d = 1'b1;
        mdata_d  = bus.hout;
        mlast_d  = (ocol_q == IMG_W - 16'd1);
        ocol_d   = ocol_q + 16'd1;
        if (ocol_q == IMG_W - 16'd1) ost_d = O_IDLE;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_CLEAR;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        clr_d = 1'b1;
        col_d = '0;
        if (bus.s_valid) state_d = S_ROW;
      end
      S_ROW: begin
        if (bus.s_valid) begin
          hin_d  = bus.s_data;
          step_d = 1'b1;
          tag_d  = last_col ? 2'b01 : 2'b11;
          col_d  = col_q + 16'd1;
          if (col_q == '0) begin
            ost_d = O_WAIT;
            dly_d = '0;
          end
          if (last_col) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
          end
        end else begin
          err_d   = 1'b1;
          ost_d   = O_IDLE;
          state_d = S_CLEAR;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == DP_LAT - 16'd1) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (!gap_end) begin
          cnt_d = cnt_q + 16'd1;
        end else if (row_q < IMG_H - 16'd1) begin
          state_d = S_CLEAR;
          row_d   = row_q + 16'd1;
        end else if (ost_q == O_IDLE) begin
          // Last row: hold here until its final word has left, so done follows m_last.
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      ost_d    = O_IDLE;
      clr_d    = 1'b1;
      hin_d    = '0;
      tag_d    = 2'b00;
      step_d   = 1'b0;
      mdata_d  = '0;
      mvalid_d = 1'b0;
      mlast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge hres_n) begin
    if (!hres_n) begin
      state_q  <= S_IDLE;
      ost_q    <= O_IDLE;
      col_q    <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
      dly_q    <= '0;
      ocol_q   <= '0;
      hin_q    <= '0;
      tag_q    <= 2'b00;
      clr_q    <= 1'b0;
      step_q   <= 1'b0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ost_q    <= ost_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      err_q    <= err_d;
      dly_q    <= dly_d;
      ocol_q   <= ocol_d;
      hin_q    <= hin_d;
      tag_q    <= tag_d;
      clr_q    <= clr_d;
      step_q   <= step_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
    end
  end

  assign bus.s_ready    = (state_q == S_ROW);
  assign bus.hin        = hin_q;
  assign bus.hrowend    = tag_q;
  assign bus.hclrbuffer = clr_q;
  assign bus.step       = step_q;
  assign bus.m_data     = mdata_q;
  assign bus.m_valid    = mvalid_q;
  assign bus.m_last     = mlast_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_underrun   = err_q;
  assign row_idx        = row_q;

endmodule

// File: tb/tb_hconv_row_sequencer.sv
// Randomized bench for hconv_row_sequencer: a delay-line datapath stand-in plus
// a row/column reference of the expected datapath and output streams.
module tb_hconv_row_sequencer;
  localparam int WI = 4, HI = 2, DPI = 6;
  localparam int H1 = 3, DP1 = 3;

  logic clk = 1'b0;
  logic hres_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, start1 = 1'b0;
  logic busy, done, err;
  logic busy1, done1, err1;
  logic [15:0] row_idx, row_idx1;

  hconv_row_sequencer_if bus ();
  hconv_row_sequencer_if bus1 ();

  hconv_row_sequencer #(.IMG_W(16'd4), .IMG_H(16'd2), .DP_LAT(16'd6), .GAP(8'd2)) dut (
    .clk(clk), .hres_n(hres_n), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .err_underrun(err), .row_idx(row_idx)
  );

  hconv_row_sequencer #(.IMG_W(16'd1), .IMG_H(16'd3), .DP_LAT(16'd3), .GAP(8'd1)) dut1 (
    .clk(clk), .hres_n(hres_n), .start(start1), .abort(1'b0), .bus(bus1),
    .busy(busy1), .done(done1), .err_underrun(err1), .row_idx(row_idx1)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: hout is hin from DP_LAT cycles earlier, scrambled.
  logic [15:0] pipe [DPI];
  logic [15:0] pipe1 [DP1];
  always @(posedge clk) begin
    pipe[0] <= bus.hin;
    for (int i = 1; i < DPI; i++) pipe[i] <= pipe[i-1];
    pipe1[0] <= bus1.hin;
    for (int i = 1; i < DP1; i++) pipe1[i] <= pipe1[i-1];
  end
  assign bus.hout  = pipe[DPI-1] ^ 16'h5A5A;
  assign bus1.hout = pipe1[DP1-1] ^ 16'h5A5A;

  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [15:0] pix [HI][WI];
  int beat_cyc [HI][WI];
  int mrow, mcol, orow, ocol, nout, nlast, ndone, last_cyc, done_cyc;
  int src_row, src_col, inj_row, inj_col;
  bit inj_pending;
  int n1_step = 0, n1_out = 0, n1_done = 0, n1_xfer = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
    check_eq({tag, "_row_idx"}, 32'(row_idx), 32'd0);
    check_eq({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    check_eq({tag, "_hin"}, 32'(bus.hin), 32'd0);
    check_eq({tag, "_hrowend"}, 32'(bus.hrowend), 32'd0);
    check_eq({tag, "_hclr"}, 32'(bus.hclrbuffer), 32'd0);
    check_eq({tag, "_step"}, 32'(bus.step), 32'd0);
    check_eq({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    check_eq({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    check_eq({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
  endtask

  task automatic sample();
    if (bus.hclrbuffer) mcol = 0;
    if (bus.step) begin
      if (mrow < HI) begin
        check_eq("hin", 32'(bus.hin), 32'(pix[mrow][mcol]));
        check_eq("hrowend", 32'(bus.hrowend), (mcol == WI-1) ? 32'd1 : 32'd3);
        check_eq("row_idx", 32'(row_idx), 32'(mrow));
        beat_cyc[mrow][mcol] = cyc;
      end else check_eq("extra_step", 32'(bus.step), 32'd0);
      mcol++;
      if (mcol == WI) begin mcol = 0; mrow++; end
    end
    if (bus.m_valid) begin
      if (orow < HI) begin
        check_eq("m_data", 32'(bus.m_data), 32'(pix[orow][ocol] ^ 16'h5A5A));
        check_eq("m_last", 32'(bus.m_last), 32'(ocol == WI-1));
        check_eq("latency", 32'(cyc - beat_cyc[orow][ocol]), 32'(DPI+1));
      end else check_eq("extra_out", 32'(bus.m_valid), 32'd0);
      if (bus.m_last) begin nlast++; last_cyc = cyc; end
      nout++;
      ocol++;
      if (ocol == WI) begin ocol = 0; orow++; end
    end
    if (done) begin ndone++; done_cyc = cyc; end
    if (bus1.step) begin
      check_eq("w1_hrowend", 32'(bus1.hrowend), 32'd1);
      n1_step++;
    end
    if (bus1.m_valid) begin
      check_eq("w1_m_last", 32'(bus1.m_last), 32'd1);
      check_eq("w1_m_data", 32'(bus1.m_data), 32'((16'h100 + 16'(n1_out)) ^ 16'h5A5A));
      n1_out++;
    end
    if (done1) n1_done++;
  endtask

  task automatic drive();
    if (bus.s_ready && inj_pending && src_row == inj_row && src_col == inj_col) begin
      bus.s_valid = 1'b0;
      inj_pending = 1'b0;
      src_col = 0;
    end else if (bus.s_ready && src_row < HI) begin
      bus.s_valid = 1'b1;
      bus.s_data = pix[src_row][src_col];
      src_col++;
      if (src_col == WI) begin src_col = 0; src_row++; end
    end else begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data = 16'($urandom);
    end
    bus1.s_valid = 1'b1;
    bus1.s_data = 16'h100 + 16'(n1_xfer);
    if (bus1.s_ready) n1_xfer++;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample();
    drive();
  endtask

  task automatic model_init();
    mrow = 0; mcol = 0; orow = 0; ocol = 0;
    nout = 0; nlast = 0; ndone = 0; last_cyc = -100; done_cyc = 0;
    src_row = 0; src_col = 0; inj_pending = 1'b0;
    for (int r = 0; r < HI; r++)
      for (int c = 0; c < WI; c++) begin
        pix[r][c] = 16'($urandom);
        beat_cyc[r][c] = 0;
      end
  endtask

  task automatic run_frame(input bit inj, input int ir, input int ic, input bit poke);
    bit poked = 1'b0;
    model_init();
    inj_pending = inj; inj_row = ir; inj_col = ic;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("err_cleared", 32'(err), 32'd0);
    check_eq("row_start", 32'(row_idx), 32'd0);
    for (int i = 0; i < 400 && ndone == 0; i++) begin
      if (poke && !poked && bus.s_ready) begin start = 1'b1; poked = 1'b1; end
      tick();
      start = 1'b0;
    end
    check_eq("done_once", 32'(ndone), 32'd1);
    check_eq("n_out", 32'(nout), 32'(HI*WI));
    check_eq("n_last", 32'(nlast), 32'(HI));
    check_eq("done_after_last", 32'(done_cyc - last_cyc), 32'd1);
    check_eq("err_underrun", 32'(err), 32'(inj));
    tick();
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("done_pulse", 32'(done), 32'd0);
    repeat (5) tick();
    check_eq("no_extra_done", 32'(ndone), 32'd1);
    check_eq("no_extra_out", 32'(nout), 32'(HI*WI));
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0;
    bus1.s_valid = 1'b0; bus1.s_data = '0;
    model_init();
    repeat (2) tick();
    check_zero("rst");
    hres_n = 1'b1;
    tick();

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    run_frame(1'b0, 0, 0, 1'b0);
    run_frame(1'b1, 0, 2, 1'b0);
    run_frame(1'b1, int'($urandom_range(0, HI-1)), int'($urandom_range(0, WI-1)), 1'b1);

    // abort while row 0 is flushing
    model_init();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && mrow == 0; i++) tick();
    repeat (2) tick();
    check_eq("flush_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_hclr", 32'(bus.hclrbuffer), 32'd1);
    check_eq("abort_m_valid", 32'(bus.m_valid), 32'd0);
    repeat (30) tick();
    check_eq("abort_no_out", 32'(nout), 32'd0);
    check_eq("abort_no_done", 32'(ndone), 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_wins", 32'(busy), 32'd0);
    run_frame(1'b0, 0, 0, 1'b0);

    // asynchronous reset in the middle of a row
    model_init();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && mcol < 2; i++) tick();
    check_eq("mid_row_ready", 32'(bus.s_ready), 32'd1);
    #1 hres_n = 1'b0;
    #1 check_zero("async_rst");
    tick();
    hres_n = 1'b1;
    tick();
    run_frame(1'b0, 0, 0, 1'b1);

    for (int k = 0; k < 3; k++)
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, HI-1)),
                int'($urandom_range(0, WI-1)), 1'($urandom_range(0, 1)));

    check_eq("w1_steps", 32'(n1_step), 32'(H1));
    check_eq("w1_outputs", 32'(n1_out), 32'(H1));
    check_eq("w1_done", 32'(n1_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end
endmodule
